// File: rtl/serial_frame_receiver_pkg.sv
// Shared constants and state types for the sensor UART frame receiver.
// Sync pattern, default link parameters and both FSM encodings live here.
package serial_frame_receiver_pkg;

  localparam int DEF_CLKS_PER_BIT  = 12;
  localparam int DEF_PAYLOAD_BYTES = 34;
  localparam int DEF_TIMEOUT_CLKS  = 480;

  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  typedef enum logic [1:0] {
    BYTE_IDLE,
    BYTE_START,
    BYTE_DATA,
    BYTE_STOP
  } byte_state_t;

  typedef enum logic [1:0] {
    HUNT0,
    HUNT1,
    PAYLOAD,
    CSUM
  } frame_state_t;

endpackage

// File: rtl/serial_frame_receiver_uart_rx_byte.sv
// 8N1 byte deserialiser: 2-FF synchroniser (preset high) plus IDLE/START/DATA/STOP FSM.
// byte_valid / byte_err are single-cycle pulses issued on the stop-bit sample.
module uart_rx_byte
  import serial_frame_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  rx_byte,
  output logic        byte_valid,
  output logic        byte_err,
  output logic        busy,
  output byte_state_t state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             stop_fail;

  assign rx_s = sync[1];
  assign busy = (state != BYTE_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync       <= 2'b11;
      state      <= BYTE_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      stop_fail  <= 1'b0;
    end else begin
      sync       <= {sync[0], rx};
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (state)
        // IDLE is only entered with the line high, so a low level marks a falling edge.
        BYTE_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= BYTE_START;
        end
        BYTE_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? BYTE_IDLE : BYTE_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BYTE_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= BYTE_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BYTE_STOP: begin
          if (stop_fail) begin
            // Framing error: hold off until the line returns to idle.
            if (rx_s) begin
              stop_fail <= 1'b0;
              state     <= BYTE_IDLE;
            end
          end else if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
              state      <= BYTE_IDLE;
            end else begin
              byte_err  <= 1'b1;
              stop_fail <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= BYTE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// Sensor link frame receiver: hunts AA 55, collects the payload with XOR checksum and inter-byte
// timeout. Handshake: data_avl is a level held until a data_ack pulse; a good frame arriving
// on the same cycle as data_ack is loaded and data_avl stays high.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
  parameter int PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
  parameter int TIMEOUT_CLKS  = DEF_TIMEOUT_CLKS
) (
  input  logic                         clk_12MHz,
  input  logic                         reset,
  input  logic                         rx,
  input  logic                         data_ack,
  output logic [8*PAYLOAD_BYTES-1:0]   sensor_iterations,
  output logic                         data_avl,
  output logic                         frame_error,
  output logic                         overrun
);

  localparam int W     = 8 * PAYLOAD_BYTES;
  localparam int IDX_W = $clog2(PAYLOAD_BYTES);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT_CLKS);

  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             byte_err;
  logic             busy;
  byte_state_t      byte_state;

  frame_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       csum;
  logic [W-1:0]     staging;
  logic [TMO_W-1:0] idle_cnt;
  logic             in_frame;
  logic             timeout;
  logic             good;
  logic             unused;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk_12MHz),
    .reset     (reset),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .busy      (busy),
    .state     (byte_state)
  );

  assign unused   = ^{busy, byte_state};
  assign in_frame = (state == PAYLOAD) || (state == CSUM);
  assign timeout  = in_frame && !byte_valid && (idle_cnt == TMO_LAST);
  assign good     = (state == CSUM) && byte_valid && (rx_byte == csum);

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      state             <= HUNT0;
      idx               <= '0;
      csum              <= '0;
      staging           <= '0;
      idle_cnt          <= '0;
      sensor_iterations <= '0;
      data_avl          <= 1'b0;
      frame_error       <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;

      if (byte_valid)             idle_cnt <= '0;
      else if (idle_cnt != TMO_SAT) idle_cnt <= idle_cnt + 1'b1;

      case (state)
        HUNT0: begin
          if (byte_valid && rx_byte == SYNC0) state <= HUNT1;
        end
        HUNT1: begin
          if (byte_err) begin
            state <= HUNT0;
          end else if (byte_valid) begin
            if (rx_byte == SYNC1) begin
              state <= PAYLOAD;
              idx   <= '0;
              csum  <= '0;
            end else if (rx_byte != SYNC0) begin
              state <= HUNT0;
            end
          end
        end
        PAYLOAD: begin
          if (byte_err || timeout) begin
            frame_error <= 1'b1;
            state       <= HUNT0;
          end else if (byte_valid) begin
            staging <= {staging[W-9:0], rx_byte};
            csum    <= csum ^ rx_byte;
            if (idx == IDX_LAST) state <= CSUM;
            else                 idx   <= idx + 1'b1;
          end
        end
        CSUM: begin
          if (byte_err || timeout) begin
            frame_error <= 1'b1;
            state       <= HUNT0;
          end else if (byte_valid) begin
            if (rx_byte != csum) frame_error <= 1'b1;
            state <= HUNT0;
          end
        end
        default: state <= HUNT0;
      endcase

      if (good) begin
        if (!data_avl || data_ack) begin
          sensor_iterations <= staging;
          data_avl          <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_ack) begin
        data_avl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed + randomized bench for serial_frame_receiver: drives 8N1 frames on rx and
// compares outputs with a frame-level model (expected payload queue, error/overrun counts).
module tb_serial_frame_receiver;

  localparam int CPB = 12;
  localparam int NB  = 34;
  localparam int W   = 8 * NB;

  logic         clk_12MHz = 1'b0;
  logic         reset;
  logic         rx;
  logic         data_ack;
  logic [W-1:0] sensor_iterations;
  logic         data_avl;
  logic         frame_error;
  logic         overrun;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_data;
  logic         exp_avl;
  int           exp_fe;
  int           exp_ov;

  serial_frame_receiver dut (
    .clk_12MHz        (clk_12MHz),
    .reset            (reset),
    .rx               (rx),
    .data_ack         (data_ack),
    .sensor_iterations(sensor_iterations),
    .data_avl         (data_avl),
    .frame_error      (frame_error),
    .overrun          (overrun)
  );

  // clock / pulse monitors
  always #5 clk_12MHz = ~clk_12MHz;

  always @(negedge clk_12MHz) begin
    if (!reset && frame_error) fe_cnt <= fe_cnt + 1;
    if (!reset && overrun)     ov_cnt <= ov_cnt + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] csum_of(input logic [W-1:0] p);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < NB; i++) c = c ^ p[8*i +: 8];
    return c;
  endfunction

  function automatic logic [W-1:0] rand_payload();
    logic [W-1:0] p;
    for (int i = 0; i < NB; i++) p[8*i +: 8] = 8'($urandom_range(0, 255));
    return p;
  endfunction

  // One 8N1 byte; data_ack pulses for the single cycle index ack_cyc (if >= 0).
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int ack_cyc);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(negedge clk_12MHz);
    for (int c = 0; c < 10 * CPB; c++) begin
      rx       = bits[c / CPB];
      data_ack = (c == ack_cyc);
      @(negedge clk_12MHz);
    end
    rx       = 1'b1;
    data_ack = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) @(negedge clk_12MHz);
  endtask

  // Sends AA 55, the first n_payload bytes of p, then the checksum if all were sent.
  task automatic send_frame(input logic [W-1:0] p, input logic [7:0] cs, input logic ack_last,
                            input int bad_idx, input int n_payload);
    send_byte(8'hAA, 1'b1, -1); gap();
    send_byte(8'h55, 1'b1, -1); gap();
    for (int i = 0; i < NB; i++) begin
      if (i >= n_payload) return;
      send_byte(p[8*(NB-1-i) +: 8], (i != bad_idx), -1);
      if (i == bad_idx) begin
        repeat (20) @(negedge clk_12MHz);
        return;
      end
      gap();
    end
    send_byte(cs, 1'b1, ack_last ? 117 : -1);
  endtask

  // Model of a completed good frame plus checks of the handshake outputs.
  task automatic good_frame(input string tag, input logic [W-1:0] p, input logic ack_last);
    send_frame(p, csum_of(p), ack_last, -1, NB);
    if (!exp_avl || ack_last) begin
      exp_q.push_back(p);
      exp_avl = 1'b1;
    end else begin
      exp_ov++;
    end
    repeat (4) @(negedge clk_12MHz);
    if (exp_q.size() > 0) exp_data = exp_q.pop_front();
    check({tag, "_data"}, sensor_iterations, exp_data);
    check({tag, "_avl"}, data_avl, exp_avl);
    check({tag, "_ovr"}, ov_cnt, exp_ov);
    check({tag, "_ferr"}, fe_cnt, exp_fe);
  endtask

  task automatic ack(input string tag);
    data_ack = 1'b1;
    @(negedge clk_12MHz);
    data_ack = 1'b0;
    exp_avl  = 1'b0;
    @(negedge clk_12MHz);
    check({tag, "_avl"}, data_avl, exp_avl);
    check({tag, "_hold"}, sensor_iterations, exp_data);
  endtask

  initial begin
    logic [W-1:0] p1;
    logic [W-1:0] p5a;
    logic [W-1:0] p;
    int w;

    rx = 1'b1; data_ack = 1'b0; reset = 1'b1;
    exp_data = '0; exp_avl = 1'b0; exp_fe = 0; exp_ov = 0;
    for (int i = 0; i < NB; i++) p1[8*(NB-1-i) +: 8] = 8'(i);
    for (int i = 0; i < NB; i++) p5a[8*i +: 8] = 8'h5A;

    repeat (3) @(negedge clk_12MHz);
    check("rst_data", sensor_iterations, '0);
    check("rst_avl", data_avl, 1'b0);
    check("rst_ferr", frame_error, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk_12MHz);

    // 1: counting payload
    good_frame("t1", p1, 1'b0);
    check("t1_msb", sensor_iterations[W-1 -: 8], 8'h00);
    check("t1_lsb", sensor_iterations[7:0], 8'h21);
    ack("t1_ack");
    ack("t1_ack_idle");

    // 2: bad checksum
    send_frame(p1, 8'h20, 1'b0, -1, NB);
    exp_fe++;
    repeat (4) @(negedge clk_12MHz);
    check("t2_ferr", fe_cnt, exp_fe);
    check("t2_avl", data_avl, exp_avl);
    check("t2_data", sensor_iterations, exp_data);

    // 3: overrun, then ack coinciding with completion
    good_frame("t3a", p1, 1'b0);
    good_frame("t3b", p5a, 1'b0);
    good_frame("t3c", rand_payload(), 1'b1);
    ack("t3_ack");

    // 4: stop-bit error on payload byte 10, then a clean frame
    send_frame(rand_payload(), 8'h00, 1'b0, 10, NB);
    exp_fe++;
    check("t4_ferr", fe_cnt, exp_fe);
    check("t4_avl", data_avl, exp_avl);
    good_frame("t4b", rand_payload(), 1'b0);
    ack("t4_ack");

    // 5: sync overlap AA AA 55, then an idle-line glitch
    send_byte(8'hAA, 1'b1, -1);
    good_frame("t5a", rand_payload(), 1'b0);
    ack("t5_ack");
    rx = 1'b0;
    repeat (3) @(negedge clk_12MHz);
    rx = 1'b1;
    repeat (40) @(negedge clk_12MHz);
    check("t5_glitch_ferr", fe_cnt, exp_fe);
    check("t5_glitch_avl", data_avl, 1'b0);
    good_frame("t5b", rand_payload(), 1'b0);

    // 6: stall after payload byte 5 until the inter-byte timeout fires
    send_frame(rand_payload(), 8'h00, 1'b0, -1, 6);
    w = 0;
    while (w < 600 && !frame_error) begin
      @(negedge clk_12MHz);
      w++;
    end
    exp_fe++;
    $display("timeout seen after %0d cycles", w);
    check("t6_tmo_window", (w >= 470 && w <= 490), 1'b1);
    repeat (3) @(negedge clk_12MHz);
    check("t6_ferr", fe_cnt, exp_fe);
    check("t6_data", sensor_iterations, exp_data);
    check("t6_avl", data_avl, exp_avl);

    // reset in the middle of a payload
    send_frame(rand_payload(), 8'h00, 1'b0, -1, 10);
    reset = 1'b1;
    #1;
    exp_data = '0; exp_avl = 1'b0;
    check("t6_rst_data", sensor_iterations, exp_data);
    check("t6_rst_avl", data_avl, exp_avl);
    @(negedge clk_12MHz);
    reset = 1'b0;
    repeat (3) @(negedge clk_12MHz);
    good_frame("t6b", rand_payload(), 1'b0);

    // randomized tail: random payloads with random ack behaviour
    for (int k = 0; k < 2; k++) begin
      p = rand_payload();
      good_frame("rnd", p, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) ack("rnd_ack");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
